// File: rtl/seq_det_ctrl.sv
// Word-serial overlapping "101" detector with a valid/ready handshake on both sides.
// Define SEQ_CARRY_EN to carry detector state across word boundaries.
module seq_det_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_hit,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {D0, D1, D2} det_t;

  state_t           state;
  det_t             det;
  det_t             det_next;
  logic [WIDTH-1:0] data;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    count;
  logic             bit_in;
  logic             match;
  logic             accept;

  assign accept = (state == IDLE) && in_valid && in_ready;

  always_comb begin
    bit_in   = data[idx];
    match    = (det == D2) && bit_in;
    det_next = D0;
    case (det)
      D0:      det_next = bit_in ? D1 : D0;
      D1:      det_next = bit_in ? D1 : D2;
      D2:      det_next = bit_in ? D1 : D0;
      default: det_next = D0;
    endcase
  end

  // Word capture is datapath only; control below decides when it is consumed.
  always_ff @(posedge clk) begin
    if (accept)
      data <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      det       <= D0;
      count     <= '0;
      idx       <= IW'(WIDTH - 1);
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_count <= '0;
      out_hit   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            idx      <= IW'(WIDTH - 1);
            count    <= '0;
`ifdef SEQ_CARRY_EN
            det      <= det;
`else
            det      <= D0;
`endif
          end
        end
        SHIFT: begin
          det   <= det_next;
          count <= count + CW'(match);
          idx   <= idx - 1'b1;
          if (idx == '0) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          // First DONE cycle registers the result; it is then held until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_count <= count;
            out_hit   <= (count != '0);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl (WIDTH=8); expectations follow SEQ_CARRY_EN when defined.
module tb_seq_det_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_hit;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_hit   (out_hit),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Offers one word, then waits for the result and checks latency, busy length and result.
  task automatic run_word(input logic [7:0] d, input int exp_cnt, input string tag);
    int n;
    int busy_n;
    n = 0;
    while (!in_ready && n < 30) begin
      step;
      n++;
    end
    chk({tag, " in_ready before offer"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    step;
    in_valid = 1'b0;
    in_data  = ~d;
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
    busy_n = 1;
    n = 0;
    while (!out_valid && n < 30) begin
      step;
      n++;
      if (busy) busy_n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(WIDTH + 1));
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(WIDTH));
    chk({tag, " out_count"}, 32'(out_count), 32'(exp_cnt));
    chk({tag, " out_hit"}, 32'(out_hit), 32'(exp_cnt != 0));
    chk({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    step;
    chk({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
    chk({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    int acc;
    int bz;
    int first;
    logic rdy;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #12;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_count", 32'(out_count), 32'd0);
    chk("reset out_hit", 32'(out_hit), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    step;
    reset = 1'b0;
    step;

    out_ready = 1'b1;
    run_word(8'hA5, 2, "w_a5");
    take_result("w_a5");
    run_word(8'hAA, 3, "w_aa");
    take_result("w_aa");
    run_word(8'h00, 0, "w_00");
    take_result("w_00");
    run_word(8'h01, 0, "w_01");
    take_result("w_01");
`ifdef SEQ_CARRY_EN
    run_word(8'h40, 1, "w_40 carry");
`else
    run_word(8'h40, 0, "w_40 nocarry");
`endif
    take_result("w_40");

    // Back-pressure in DONE
    out_ready = 1'b0;
    run_word(8'hAA, 3, "hold");
    for (int i = 0; i < 5; i++) begin
      step;
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold out_count", 32'(out_count), 32'd3);
      chk("hold in_ready", 32'(in_ready), 32'd0);
    end
    take_result("hold");

    // Reset in the 4th SHIFT cycle of 0xFF
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step;
    in_valid = 1'b0;
    step;
    step;
    step;
    chk("abort busy before reset", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    #1 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step;
      if (out_valid) seen++;
    end
    chk("abort no out_valid", 32'(seen), 32'd0);
    run_word(8'hA5, 2, "after abort");
    take_result("after abort");

    // in_valid held high across transactions
    in_data  = 8'hAA;
    in_valid = 1'b1;
    acc   = 0;
    bz    = 0;
    first = -1;
    for (int i = 0; i < 22; i++) begin
      rdy = in_ready;
      step;
      if (rdy) acc++;
      if (busy) bz++;
      if (out_valid && first < 0) first = int'(out_count);
    end
    in_valid = 1'b0;
    chk("stream acceptances", 32'(acc), 32'd2);
    chk("stream busy cycles", 32'(bz), 32'(2 * WIDTH));
    chk("stream first count", 32'(first), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bits per input word (legal range 2..32).
REQ-002 The block SHALL have derived parameter CW, equal to $clog2(WIDTH+1), giving the match-count width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 in_data  input  WIDTH  word to scan, serialized MSB first.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_count  output  CW  number of "101" matches found in the word.
REQ-011 out_hit  output  1  out_count is nonzero.
REQ-012 busy  output  1  a word is being serialized (SHIFT state).

Function
REQ-013 The control FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE->SHIFT on in_valid&&in_ready: latch in_data, bit index = WIDTH-1, clear the match count.
REQ-016 In SHIFT the block SHALL feed one bit per cycle, in_data[idx], from idx = WIDTH-1 down to 0, into an internal overlapping "101" Mealy detector.
REQ-017 Detector states: D0 (no prefix), D1 (seen "1"), D2 (seen "10").
REQ-018 Detector transitions: D0 -1->D1, D0 -0->D0; D1 -1->D1, D1 -0->D2; D2 -1->D1 with a match, D2 -0->D0.
REQ-019 Each match SHALL increment the count by 1, with no saturation needed since the count is at most WIDTH/2.
REQ-020 SHIFT->DONE on the cycle that consumes idx 0; there are exactly WIDTH SHIFT cycles.
REQ-021 Latency: acceptance at edge k SHALL give out_valid=1 after edge k+WIDTH+1.
REQ-022 In DONE, out_count and out_hit SHALL be held stable until out_valid&&out_ready.
REQ-023 DONE->IDLE on out_valid&&out_ready; no new word SHALL be accepted in that same cycle.
REQ-024 in_valid during SHIFT or DONE SHALL be ignored, because in_ready=0.
REQ-025 in_data changes after acceptance SHALL NOT affect the result.

Reset
REQ-026 Reset SHALL force: FSM=IDLE, detector=D0, count=0, index=WIDTH-1, in_ready=1, out_valid=0, out_count=0, out_hit=0, busy=0.
REQ-027 Reset asserted mid-SHIFT or mid-DONE SHALL abort the word and discard any partial result, with no output pulse.

Configuration
REQ-028 Macro SEQ_CARRY_EN defined: detector state SHALL carry across word boundaries, so a match may span two words and is counted in the later word.
REQ-029 Macro SEQ_CARRY_EN undefined: detector state SHALL be forced to D0 on every IDLE->SHIFT transition.
REQ-030 Reset SHALL clear the detector to D0 in both configurations.

Verification
REQ-031 Word 0xA5 (10100101), out_ready=1: out_count=2, out_hit=1, out_valid rising WIDTH+1 edges after acceptance.
REQ-032 Word 0xAA: out_count=3; then word 0x00: out_count=0, out_hit=0.
REQ-033 Words 0x01 then 0x40: second word gives out_count=1 with SEQ_CARRY_EN and out_count=0 without it.
REQ-034 Word 0xAA with out_ready=0 for 5 cycles in DONE: out_valid=1, out_count=3 stable, in_ready=0; release gives IDLE on the next edge.
REQ-035 Reset pulse on the 4th SHIFT cycle of 0xFF: no out_valid; a following word 0xA5 gives out_count=2.
REQ-036 in_valid held high across the whole transaction: exactly one acceptance per IDLE visit, and busy=1 for exactly WIDTH cycles.
